wb_csr_bank: RTL and testbench

//  Parametrised Wishbone B4 classic slave CSR bank; generational successor to the fixed MAC/IP/port CSR slave.

---
 rtl/wb_csr_bank.sv | 167 ++++++++++++++++
 tb/tb_wb_csr_bank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_csr_bank.sv
// rtl/wb_csr_bank.sv - Wishbone B4 classic CSR bank: byte-laned RW regs, RO status words, W1C IRQ status/enable
module wb_csr_bank #(
    parameter logic [31:0]          BASE_ADDR = 32'h3000_0000,
    parameter int                   NUM_RW    = 4,
    parameter int                   NUM_RO    = 2,
    parameter int                   NUM_IRQ   = 8,
    parameter logic [32*NUM_RW-1:0] RW_RESET  = '0
) (
    input  logic                                      wb_clk_i,
    input  logic                                      wb_rst_n_i,
    input  logic                                      wbs_stb_i,
    input  logic                                      wbs_cyc_i,
    input  logic                                      wbs_we_i,
    input  logic [3:0]                                wbs_sel_i,
    input  logic [31:0]                               wbs_dat_i,
    input  logic [31:0]                               wbs_adr_i,
    output logic                                      wbs_ack_o,
    output logic                                      wbs_err_o,
    output logic [31:0]                               wbs_dat_o,
    output logic [32*NUM_RW-1:0]                      csr_rw_o,
    output logic [NUM_RW-1:0]                         csr_wr_pulse_o,
    input  logic [32*((NUM_RO > 0) ? NUM_RO : 1)-1:0] csr_ro_i,
    input  logic [NUM_IRQ-1:0]                        irq_evt_i,
    output logic                                      irq_o
);

    localparam int          IDX_STATUS = NUM_RW + NUM_RO;
    localparam int          IDX_ENABLE = NUM_RW + NUM_RO + 1;
    localparam logic [29:0] MAP_WORDS  = 30'(NUM_RW + NUM_RO + 2);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [29:0]          word_idx;
    logic                 mapped;
    logic                 accept;
    logic                 do_write;
    logic [31:0]          lane_mask;
    logic [31:0]          rd_word;
    logic [31:0]          enable_merged;
    logic [NUM_IRQ-1:0]   irq_clr;

    logic [32*NUM_RW-1:0] rw_q;
    logic [NUM_RW-1:0]    pulse_q;
    logic [NUM_IRQ-1:0]   status_q;
    logic [NUM_IRQ-1:0]   enable_q;
    logic                 irq_q;
    logic                 ack_q;
    logic                 err_q;
    logic [31:0]          dat_q;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    accept     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtracting word-aligned parts keeps the index exact; the compare against BASE_ADDR rejects wrap-around.
    assign word_idx  = wbs_adr_i[31:2] - BASE_ADDR[31:2];
    assign mapped    = (wbs_adr_i >= BASE_ADDR) && (word_idx < MAP_WORDS) && (wbs_adr_i[1:0] == 2'b00);
    assign do_write  = accept && mapped && wbs_we_i;
    assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    always_comb begin
        rd_word = 32'h0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (word_idx == 30'(i)) begin
                rd_word = rw_q[32*i +: 32];
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (word_idx == 30'(NUM_RW + j)) begin
                rd_word = csr_ro_i[32*j +: 32];
            end
        end
        if (word_idx == 30'(IDX_STATUS)) begin
            rd_word = 32'(status_q);
        end
        if (word_idx == 30'(IDX_ENABLE)) begin
            rd_word = 32'(enable_q);
        end
    end

    always_comb begin
        irq_clr       = '0;
        enable_merged = (32'(enable_q) & ~lane_mask) | (wbs_dat_i & lane_mask);
        if (do_write && (word_idx == 30'(IDX_STATUS))) begin
            irq_clr = NUM_IRQ'(wbs_dat_i & lane_mask);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            rw_q    <= RW_RESET;
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (do_write && (word_idx == 30'(i))) begin
                    rw_q[32*i +: 32] <= (rw_q[32*i +: 32] & ~lane_mask) | (wbs_dat_i & lane_mask);
                    pulse_q[i]       <= |wbs_sel_i;
                end
            end
        end
    end

    // An event in the same cycle as a clear on that bit must leave it set, so OR the events in last.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            status_q <= '0;
            enable_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= (status_q & ~irq_clr) | irq_evt_i;
            if (do_write && (word_idx == 30'(IDX_ENABLE))) begin
                enable_q <= enable_merged[NUM_IRQ-1:0];
            end
            irq_q <= |(status_q & enable_q);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= 32'h0;
        end else if (accept) begin
            ack_q <= mapped;
            err_q <= !mapped;
            dat_q <= (mapped && !wbs_we_i) ? rd_word : 32'h0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end
    end

    // Reset arriving during RESP suppresses the pending response and write pulse immediately.
    assign wbs_ack_o      = ack_q & wb_rst_n_i;
    assign wbs_err_o      = err_q & wb_rst_n_i;
    assign csr_wr_pulse_o = pulse_q & {NUM_RW{wb_rst_n_i}};
    assign wbs_dat_o      = dat_q;
    assign csr_rw_o       = rw_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_wb_csr_bank.sv
// tb/tb_wb_csr_bank.sv - randomized self-checking bench for wb_csr_bank against an array-based register model
module tb_wb_csr_bank;

    localparam logic [31:0]  BASE = 32'h3000_0000;
    localparam logic [127:0] RST  = {32'hCAFE_0003, 32'h5A5A_0002, 32'h0000_0000, 32'hDEAD_BEEF};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stb = 1'b0;
    logic         cyc = 1'b0;
    logic         we = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  dat_i = 32'h0;
    logic [31:0]  adr = 32'h0;
    logic         ack;
    logic         err;
    logic [31:0]  dat_o;
    logic [127:0] csr_rw;
    logic [3:0]   pulse;
    logic [63:0]  ro = 64'h0;
    logic [7:0]   evt = 8'h0;
    logic         irq;

    wb_csr_bank #(
        .BASE_ADDR(BASE),
        .NUM_RW   (4),
        .NUM_RO   (2),
        .NUM_IRQ  (8),
        .RW_RESET (RST)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_dat_i     (dat_i),
        .wbs_adr_i     (adr),
        .wbs_ack_o     (ack),
        .wbs_err_o     (err),
        .wbs_dat_o     (dat_o),
        .csr_rw_o      (csr_rw),
        .csr_wr_pulse_o(pulse),
        .csr_ro_i      (ro),
        .irq_evt_i     (evt),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rw_m [4];
    logic [7:0]  status_m;
    logic [7:0]  enable_m;

    logic        r_ack;
    logic        r_err;
    logic        r_irq;
    logic [31:0] r_dat;
    logic [3:0]  r_pulse;
    logic [127:0] r_rw;

    function automatic logic [127:0] model_pack();
        return {rw_m[3], rw_m[2], rw_m[1], rw_m[0]};
    endfunction

    function automatic logic [31:0] model_read(int idx);
        if (idx < 4) return rw_m[idx];
        if (idx < 6) return ro[32*(idx-4) +: 32];
        if (idx == 6) return {24'h0, status_m};
        if (idx == 7) return {24'h0, enable_m};
        return 32'h0;
    endfunction

    function automatic logic [31:0] byte_mask(logic [3:0] s);
        logic [31:0] m = 32'h0;
        for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 4; i++) rw_m[i] = RST[32*i +: 32];
        status_m = 8'h0;
        enable_m = 8'h0;
    endtask

    // Starts at a negedge in IDLE; returns at the negedge after the response cycle.
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [7:0] e);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d; evt = e;
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; evt = 8'h0;
        @(negedge clk);
        r_ack = ack; r_err = err; r_dat = dat_o; r_pulse = pulse; r_irq = irq; r_rw = csr_rw;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", ack); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
        vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_dat got %h want 0", dat_o); end
        vectors++; if (pulse !== 4'h0) begin miscompares++; $display("FAIL reset_pulse got %h want 0", pulse); end
        vectors++; if (csr_rw !== RST) begin miscompares++; $display("FAIL reset_regs got %h want %h", csr_rw, RST); end
        rst_n = 1'b1;
        reset_model();
        @(negedge clk);
        access(1'b0, BASE, 4'hF, 32'h0, 8'h0);
        vectors++; if (r_ack !== 1'b1) begin miscompares++; $display("FAIL reset_read_ack got %b want 1", r_ack); end
        vectors++; if (r_err !== 1'b0) begin miscompares++; $display("FAIL reset_read_err got %b want 0", r_err); end
        vectors++; if (r_dat !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL reset_read_dat got %h want deadbeef", r_dat); end
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_read_ack_width got %b want 0", ack); end
    endtask

    task automatic test_byte_write();
        access(1'b1, BASE + 32'h4, 4'b0101, 32'h1122_3344, 8'h0);
        rw_m[1] = 32'h0022_0044;
        vectors++; if (r_ack !== 1'b1) begin miscompares++; $display("FAIL bytewr_ack got %b want 1", r_ack); end
        vectors++; if (r_pulse !== 4'b0010) begin miscompares++; $display("FAIL bytewr_pulse got %b want 0010", r_pulse); end
        vectors++; if (r_rw[63:32] !== 32'h0022_0044) begin miscompares++; $display("FAIL bytewr_reg1 got %h want 00220044", r_rw[63:32]); end
        vectors++; if (pulse !== 4'b0000) begin miscompares++; $display("FAIL bytewr_pulse_width got %b want 0000", pulse); end
        access(1'b1, BASE + 32'h8, 4'b0000, 32'hFFFF_FFFF, 8'h0);
        vectors++; if (r_ack !== 1'b1) begin miscompares++; $display("FAIL sel0_ack got %b want 1", r_ack); end
        vectors++; if (r_pulse !== 4'b0000) begin miscompares++; $display("FAIL sel0_pulse got %b want 0000", r_pulse); end
        vectors++; if (r_rw !== model_pack()) begin miscompares++; $display("FAIL sel0_regs got %h want %h", r_rw, model_pack()); end
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [3];
        logic        ws [3];
        addrs[0] = BASE + 32'h40; ws[0] = 1'b0;
        addrs[1] = BASE + 32'h2;  ws[1] = 1'b0;
        addrs[2] = BASE + 32'h40; ws[2] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            access(ws[t], addrs[t], 4'hF, 32'hA5A5_A5A5, 8'h0);
            vectors++; if (r_err !== 1'b1) begin miscompares++; $display("FAIL unmapped_err[%0d] got %b want 1", t, r_err); end
            vectors++; if (r_ack !== 1'b0) begin miscompares++; $display("FAIL unmapped_ack[%0d] got %b want 0", t, r_ack); end
            vectors++; if (r_dat !== 32'h0) begin miscompares++; $display("FAIL unmapped_dat[%0d] got %h want 0", t, r_dat); end
            vectors++; if (r_rw !== model_pack()) begin miscompares++; $display("FAIL unmapped_regs[%0d] got %h want %h", t, r_rw, model_pack()); end
        end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL unmapped_err_width got %b want 0", err); end
    endtask

    task automatic test_irq();
        access(1'b1, BASE + 32'h1C, 4'hF, 32'h0000_0008, 8'h0);
        enable_m = 8'h08;
        evt = 8'h08;
        @(posedge clk);
        #1;
        evt = 8'h0;
        status_m = status_m | 8'h08;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rise got %b want 1", irq); end
        access(1'b0, BASE + 32'h18, 4'hF, 32'h0, 8'h0);
        vectors++; if (r_dat !== 32'h0000_0008) begin miscompares++; $display("FAIL irq_status got %h want 00000008", r_dat); end
        access(1'b1, BASE + 32'h18, 4'hF, 32'h0000_0008, 8'h0);
        status_m = 8'h0;
        vectors++; if (r_irq !== 1'b1) begin miscompares++; $display("FAIL irq_hold_in_resp got %b want 1", r_irq); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_fall got %b want 0", irq); end
        access(1'b0, BASE + 32'h18, 4'hF, 32'h0, 8'h0);
        vectors++; if (r_dat !== 32'h0) begin miscompares++; $display("FAIL irq_cleared got %h want 0", r_dat); end
    endtask

    task automatic test_set_wins();
        access(1'b1, BASE + 32'h18, 4'hF, 32'h0000_0008, 8'h08);
        status_m = 8'h08;
        access(1'b0, BASE + 32'h18, 4'hF, 32'h0, 8'h0);
        vectors++; if (r_dat !== 32'h0000_0008) begin miscompares++; $display("FAIL set_wins got %h want 00000008", r_dat); end
        access(1'b1, BASE + 32'h18, 4'hF, 32'h0000_00FF, 8'h0);
        status_m = 8'h0;
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        logic exp_ack;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'hC; sel = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_ack = (c % 2 == 0);
            vectors++; if (ack !== exp_ack) begin miscompares++; $display("FAIL b2b_ack[%0d] got %b want %b", c, ack, exp_ack); end
            if (ack === 1'b1) begin
                acks++;
                vectors++; if (dat_o !== rw_m[3]) begin miscompares++; $display("FAIL b2b_dat[%0d] got %h want %h", c, dat_o, rw_m[3]); end
            end
        end
        stb = 1'b0; cyc = 1'b0;
        vectors++; if (acks != 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", acks); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_resp();
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; dat_i = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rstresp_ack got %b want 0", ack); end
        vectors++; if (pulse !== 4'h0) begin miscompares++; $display("FAIL rstresp_pulse got %h want 0", pulse); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        @(negedge clk);
        vectors++; if (csr_rw !== RST) begin miscompares++; $display("FAIL rstresp_regs got %h want %h", csr_rw, RST); end
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rstresp_late_ack got %b want 0", ack); end
        access(1'b0, BASE, 4'hF, 32'h0, 8'h0);
        vectors++; if (r_dat !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rstresp_read got %h want deadbeef", r_dat); end
    endtask

    task automatic test_random();
        int          kind;
        int          idx;
        logic        mapped;
        logic        w;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] a;
        logic [7:0]  e;
        logic [31:0] m;
        logic [31:0] exp_dat;
        logic [3:0]  exp_pulse;
        logic        exp_irq;
        logic [7:0]  clr;
        for (int n = 0; n < 300; n++) begin
            if (n % 50 == 0) ro = {$urandom, $urandom};
            kind = $urandom_range(0, 11);
            if (kind <= 7) begin
                idx = kind; a = BASE + 32'(4 * idx);
            end else if (kind <= 9) begin
                idx = 8 + $urandom_range(0, 20); a = BASE + 32'(4 * idx);
            end else if (kind == 10) begin
                idx = $urandom_range(0, 7); a = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
            end else begin
                idx = -1; a = BASE - 32'(4 * $urandom_range(1, 8));
            end
            mapped = (kind <= 7);
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom);
            d = $urandom;
            e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            m = byte_mask(s);

            exp_irq   = |(status_m & enable_m);
            exp_dat   = (mapped && !w) ? model_read(idx) : 32'h0;
            exp_pulse = 4'h0;
            clr       = 8'h0;
            if (mapped && w) begin
                if (idx < 4) begin
                    rw_m[idx] = (rw_m[idx] & ~m) | (d & m);
                    if (s != 4'h0) exp_pulse[idx] = 1'b1;
                end else if (idx == 6) begin
                    clr = d[7:0] & m[7:0];
                end else if (idx == 7) begin
                    enable_m = (enable_m & ~m[7:0]) | (d[7:0] & m[7:0]);
                end
            end
            status_m = (status_m & ~clr) | e;

            access(w, a, s, d, e);
            vectors++; if (r_ack !== mapped) begin miscompares++; $display("FAIL rnd_ack[%0d] adr=%h got %b want %b", n, a, r_ack, mapped); end
            vectors++; if (r_err !== !mapped) begin miscompares++; $display("FAIL rnd_err[%0d] adr=%h got %b want %b", n, a, r_err, !mapped); end
            if (!w || !mapped) begin
                vectors++; if (r_dat !== exp_dat) begin miscompares++; $display("FAIL rnd_dat[%0d] adr=%h got %h want %h", n, a, r_dat, exp_dat); end
            end
            vectors++; if (r_pulse !== exp_pulse) begin miscompares++; $display("FAIL rnd_pulse[%0d] got %b want %b", n, r_pulse, exp_pulse); end
            vectors++; if (r_irq !== exp_irq) begin miscompares++; $display("FAIL rnd_irq[%0d] got %b want %b", n, r_irq, exp_irq); end
            vectors++; if (r_rw !== model_pack()) begin miscompares++; $display("FAIL rnd_regs[%0d] got %h want %h", n, r_rw, model_pack()); end
        end
    endtask

    initial begin
        reset_model();
        test_reset();
        test_byte_write();
        test_unmapped();
        test_irq();
        test_set_wins();
        test_back_to_back();
        test_random();
        test_reset_in_resp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
